// File: rtl/serdes_pkg.sv
// Shared serdes definitions: FSM state encoding, default word width, parity helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a. Also imported by serializer_PISO.
package serdes_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } ser_state_t;

  // Returns 1 when the vector holds an odd number of ones, i.e. it violates
  // even parity once the parity bit is included in the vector.
  function automatic logic parity_odd(input logic [32:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/deserializer_sipo_if.sv
// Parallel word port of the deserializer: DOUT/ready from the receiver, ACK from downstream.
// Latency: n/a (wiring only).
// Backpressure: the word is held while ready=1 until ACK is seen with ready=1.
// master: the receiver (drives DOUT, ready; samples ACK).
// slave:  the downstream consumer (samples DOUT, ready; drives ACK).
interface deserializer_sipo_if
  import serdes_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
  logic [DATA_WIDTH-1:0] DOUT;
  logic                  ready;
  logic                  ACK;

  modport master (output DOUT, output ready, input ACK);
  modport slave  (input DOUT, input ready, output ACK);
endinterface

// File: rtl/sipo_shift_reg.sv
// MSB-first shift register with bit counter; flags the strobe that samples the last data bit.
// Latency: word_done is combinational on the final strobe; shreg holds the full word one cycle later.
// Backpressure: none, shifts on every shift_en; clr (abort) has priority over shifting.
// Ports: clk, rst (async active-low), clr, shift_en, sdi in; shreg, word_done out.
module sipo_shift_reg
  import serdes_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  shift_en,
  input  logic                  sdi,
  output logic [DATA_WIDTH-1:0] shreg,
  output logic                  word_done
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

  logic [CNT_W-1:0] bit_cnt;

  // bit_cnt counts bits already captured, so the strobe arriving while it
  // equals DATA_WIDTH-1 is the one that completes the word.
  assign word_done = shift_en && (bit_cnt == LAST_CNT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (clr) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (shift_en) begin
      shreg   <= {shreg[DATA_WIDTH-2:0], sdi};
      bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/deserializer_sipo.sv
// Serial-in/parallel-out receiver: frames MSB-first bits into DATA_WIDTH words, flags frame/overrun errors.
// Latency: word visible on DOUT/ready the cycle after the strobe sampling the last bit (parity bit if enabled).
// Backpressure: one-word output register; a word completing while ready=1 and ACK=0 is dropped (overrun pulse).
// Ports: clk, rst (async active-low); RX_active, shift, SDI serial side; par (DOUT/ready/ACK) parallel side;
//        busy, frame_err, overrun status (all registered).
// Build option: define DESER_PARITY_EN to append and check one even-parity bit per frame.
module deserializer_sipo
  import serdes_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                RX_active,
  input  logic                shift,
  input  logic                SDI,
  deserializer_sipo_if.master par,
  output logic                busy,
  output logic                frame_err,
  output logic                overrun
);

  ser_state_t state_q, state_d;

  logic                  shift_en;
  logic                  word_done;
  logic                  abort;
  logic                  deliver;
  logic                  par_fail;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] word;

  logic [DATA_WIDTH-1:0] dout_q;
  logic                  ready_q;
  logic                  busy_q;
  logic                  frame_err_q;
  logic                  overrun_q;

  // A frame starts only on a strobe inside the envelope; once in SHIFT every
  // strobe is taken so that the final bit still counts if RX_active falls with it.
  assign shift_en = shift && ((state_q == IDLE && RX_active) || state_q == SHIFT);

  sipo_shift_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_shift_reg (
    .clk      (clk),
    .rst      (rst),
    .clr      (abort),
    .shift_en (shift_en),
    .sdi      (SDI),
    .shreg    (shreg),
    .word_done(word_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (RX_active && shift) state_d = SHIFT;
      end
      SHIFT: begin
        if (word_done) begin
`ifdef DESER_PARITY_EN
          state_d = PARITY;
`else
          state_d = IDLE;
`endif
        end else if (!RX_active) begin
          state_d = IDLE;
        end
      end
`ifdef DESER_PARITY_EN
      PARITY: begin
        if (shift || !RX_active) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    abort    = 1'b0;
    deliver  = 1'b0;
    par_fail = 1'b0;
    // Default view of the word: the shift register plus the bit being sampled now.
    word     = {shreg[DATA_WIDTH-2:0], SDI};
    case (state_q)
      SHIFT: begin
        abort = !RX_active && !word_done;
`ifndef DESER_PARITY_EN
        deliver = word_done;
`endif
      end
`ifdef DESER_PARITY_EN
      PARITY: begin
        // The data word is already complete in shreg; SDI now carries parity.
        word = shreg;
        if (shift) begin
          par_fail = parity_odd(33'({shreg, SDI}));
          deliver  = !par_fail;
        end else if (!RX_active) begin
          abort = 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_q      <= '0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      busy_q      <= (state_d != IDLE);
      frame_err_q <= abort || par_fail;
      overrun_q   <= deliver && ready_q && !par.ACK;
      // An ACK on the completion cycle frees the register for the new word.
      if (deliver && (!ready_q || par.ACK)) begin
        dout_q  <= word;
        ready_q <= 1'b1;
      end else if (ready_q && par.ACK) begin
        ready_q <= 1'b0;
      end
    end
  end

  assign par.DOUT  = dout_q;
  assign par.ready = ready_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule
